// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit and/or/add/slt slice walked LSB first.
// Optional `ALU_ZERO_FLAG_EN adds a registered zero flag output.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             binvert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SLT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             binv_q, binv_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // Operands shift right each RUN cycle so the active bit is always at [0].
    logic a_bit, b_raw, b2, sum, cout, set, last, slice_bit, ovf_msb;
    logic [WIDTH-1:0] res_shift, res_final;

    always_comb begin
        a_bit   = a_q[0];
        b_raw   = b_q[0];
        b2      = b_raw ^ binv_q;
        sum     = a_bit ^ b2 ^ carry_q;
        cout    = (a_bit & b2) | (a_bit & carry_q) | (b2 & carry_q);
        last    = (cnt_q == CW'(WIDTH - 1));
        set     = (a_bit != b2) ? sum : a_bit;
        ovf_msb = (op_q == OP_ADD) & (a_bit == b2) & (sum != a_bit);
        slice_bit = 1'b0;
        unique case (op_q)
            OP_AND:  slice_bit = a_bit & b_raw;
            OP_OR:   slice_bit = a_bit | b_raw;
            OP_ADD:  slice_bit = sum;
            OP_SLT:  slice_bit = 1'b0;
            default: slice_bit = 1'b0;
        endcase
        res_shift = {slice_bit, res_q[WIDTH-1:1]};
        res_final = (op_q == OP_SLT) ? WIDTH'(set) : res_shift;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        binv_d    = binv_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
`ifdef ALU_ZERO_FLAG_EN
        zero_d    = zero_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    binv_d  = binvert;
                    carry_d = binvert;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cout;
                if (last) begin
                    res_d   = res_final;
                    ovf_d   = ovf_msb;
                    cnt_d   = '0;
                    state_d = S_DONE;
`ifdef ALU_ZERO_FLAG_EN
                    zero_d  = (res_final == '0);
`endif
                end else begin
                    res_d = res_shift;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef ALU_ZERO_FLAG_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            binv_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            binv_q  <= binv_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
`ifdef ALU_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign result   = res_q;
    assign overflow = ovf_q;
`ifdef ALU_ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl at WIDTH=8: directed ops, arithmetic model,
// handshake hold and mid-run reset abort.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'd0;
    logic         binvert = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         overflow;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero;
`endif

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .binvert(binvert),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .overflow(overflow)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns {overflow, result} from signed integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] ma,
                                         input logic [7:0] mb,
                                         input logic [1:0] mop,
                                         input logic mbinv);
        int sa, sb, t;
        logic [7:0] r;
        logic v;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        v = 1'b0;
        r = '0;
        case (mop)
            2'd0: r = ma & mb;
            2'd1: r = ma | mb;
            2'd2: begin
                t = mbinv ? sa - sb : sa + sb;
                r = t[7:0];
                v = (t > 127) || (t < -128);
            end
            default: begin
                t = mbinv ? sa - sb : sa + sb;
                r = {7'b0, t < 0};
            end
        endcase
        return {v, r};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                chk("in_ready low while out_valid", in_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected out_valid", 1, 0);
                end else begin
                    chk("model result", result, exp_q[0][7:0]);
                    chk("model overflow", overflow, exp_q[0][8]);
`ifdef ALU_ZERO_FLAG_EN
                    chk("model zero", zero, exp_q[0][7:0] == 0);
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
`ifdef ALU_ZERO_FLAG_EN
                chk("zero low outside DONE", zero, 0);
`endif
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, op, binvert));
        end
    end

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb,
                            input logic [1:0] top, input logic tbinv);
        logic acc;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        op = top;
        binvert = tbinv;
        acc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk("accept within bound", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: the DUT must be using its latched copy.
        a = 8'($urandom);
        b = 8'($urandom);
        op = 2'($urandom);
        binvert = 1'($urandom);
    endtask

    // Counts negedges after the accept edge; the accept edge itself is edge 1.
    task automatic wait_done(input string nm);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, lat, W + 1);
    endtask

    task automatic run_op(input string nm, input logic [7:0] ta,
                          input logic [7:0] tb, input logic [1:0] top,
                          input logic tbinv, input logic [7:0] er,
                          input logic eo);
        start_op(ta, tb, top, tbinv);
        wait_done(nm);
        chk({nm, " result"}, result, er);
        chk({nm, " overflow"}, overflow, eo);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic seen;
        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset overflow", overflow, 0);
`ifdef ALU_ZERO_FLAG_EN
        chk("reset zero", zero, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("add 7f+01", 8'h7F, 8'h01, 2'd2, 1'b0, 8'h80, 1'b1);
        run_op("sub 05-05", 8'h05, 8'h05, 2'd2, 1'b1, 8'h00, 1'b0);
        run_op("sub 00-01", 8'h00, 8'h01, 2'd2, 1'b1, 8'hFF, 1'b0);
        run_op("sub 80-01", 8'h80, 8'h01, 2'd2, 1'b1, 8'h7F, 1'b1);
        run_op("add ff+01", 8'hFF, 8'h01, 2'd2, 1'b0, 8'h00, 1'b0);
        run_op("slt 80,01", 8'h80, 8'h01, 2'd3, 1'b1, 8'h01, 1'b0);
        run_op("slt 7f,80", 8'h7F, 8'h80, 2'd3, 1'b1, 8'h00, 1'b0);
        run_op("slt 01,02", 8'h01, 8'h02, 2'd3, 1'b1, 8'h01, 1'b0);
        run_op("slt ff,ff", 8'hFF, 8'hFF, 2'd3, 1'b1, 8'h00, 1'b0);
        run_op("slt nb 7f,01", 8'h7F, 8'h01, 2'd3, 1'b0, 8'h00, 1'b0);
        run_op("and f0,3c", 8'hF0, 8'h3C, 2'd0, 1'b0, 8'h30, 1'b0);
        run_op("or f0,3c", 8'hF0, 8'h3C, 2'd1, 1'b0, 8'hFC, 1'b0);
        run_op("and binv", 8'hF0, 8'h3C, 2'd0, 1'b1, 8'h30, 1'b0);
        run_op("or binv", 8'h0F, 8'h81, 2'd1, 1'b1, 8'h8F, 1'b0);

        // Consumer stalls: result held, second request ignored meanwhile.
        out_ready = 1'b0;
        run_op("hold and", 8'hF0, 8'h3C, 2'd0, 1'b0, 8'h30, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = 8'h11;
            b = 8'h22;
            op = 2'd2;
            binvert = 1'b0;
            @(negedge clk);
            chk("hold result", result, 8'h30);
            chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        start_op(8'h11, 8'h22, 2'd2, 1'b0);
        wait_done("after hold");
        chk("after hold result", result, 8'h33);
        @(posedge clk);
        #1;

        // Abort mid-run.
        start_op(8'h3A, 8'h45, 2'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort result", result, 0);
        chk("abort overflow", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort no out_valid", seen, 0);
        chk("abort in_ready after", in_ready, 1);
        run_op("add 01+01", 8'h01, 8'h01, 2'd2, 1'b0, 8'h02, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
